// File: rtl/xtea_pkg.sv
// Shared XTEA types, constants and round helpers for the iterative cipher engine.
package xtea_pkg;

  localparam logic [31:0] XTEA_DELTA   = 32'h9E3779B9;
  localparam int          XTEA_BLOCK_W = 64;

  typedef logic [31:0] xtea_word_t;
  // Element 0 sits in the MSBs so a flat 128-bit key maps k[0] = [127:96].
  typedef xtea_word_t [0:3] xtea_key_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} xtea_state_e;

  function automatic xtea_word_t key_sel(input xtea_key_t key, input logic [1:0] idx);
    return key[idx];
  endfunction

  function automatic xtea_word_t mix(input xtea_word_t v);
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction

  function automatic xtea_word_t init_sum(input logic decrypt, input int rounds,
                                          input xtea_word_t delta = XTEA_DELTA);
    return decrypt ? xtea_word_t'(delta * xtea_word_t'(rounds)) : '0;
  endfunction

endpackage

// File: rtl/xtea_round.sv
// One combinational XTEA cycle (v0 half then v1 half); decrypt runs the halves in reverse.
module xtea_round
  import xtea_pkg::*;
#(
  parameter logic [31:0] DELTA = XTEA_DELTA
) (
  input  logic [31:0]  v0_i,
  input  logic [31:0]  v1_i,
  input  logic [31:0]  sum_i,
  input  logic [127:0] key_i,
  input  logic         decrypt_i,
  output logic [31:0]  v0_o,
  output logic [31:0]  v1_o,
  output logic [31:0]  sum_o
);

  xtea_key_t  key;
  xtea_word_t a0, a1, s;

  assign key = key_i;

  always_comb begin
    a0 = v0_i;
    a1 = v1_i;
    s  = sum_i;
    if (!decrypt_i) begin
      a0 = v0_i + (mix(v1_i) ^ (sum_i + key_sel(key, sum_i[1:0])));
      s  = sum_i + DELTA;
      a1 = v1_i + (mix(a0) ^ (s + key_sel(key, s[12:11])));
    end else begin
      a1 = v1_i - (mix(v0_i) ^ (sum_i + key_sel(key, sum_i[12:11])));
      s  = sum_i - DELTA;
      a0 = v0_i - (mix(a1) ^ (s + key_sel(key, s[1:0])));
    end
    v0_o  = a0;
    v1_o  = a1;
    sum_o = s;
  end

endmodule

// File: rtl/xtea_iter_core.sv
// Folded XTEA engine: UNROLL rounds per clock, result valid ROUNDS/UNROLL cycles after accept.
// Result is held in DONE until out_ready; a new block may be accepted in that same cycle.
module xtea_iter_core
  import xtea_pkg::*;
#(
  parameter int          ROUNDS = 32,
  parameter int          UNROLL = 1,
  parameter logic [31:0] DELTA  = XTEA_DELTA
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_decrypt,
  input  logic [XTEA_BLOCK_W-1:0] in_data,
  input  logic [127:0]            in_key,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XTEA_BLOCK_W-1:0] out_data,
  output logic                    busy
);

  localparam int STEPS = ROUNDS / UNROLL;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (ROUNDS < 1 || (ROUNDS % UNROLL) != 0 ||
      !(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_params
    $error("xtea_iter_core: illegal ROUNDS/UNROLL combination");
  end

  xtea_state_e             state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [31:0]             v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [127:0]            key_q, key_d;
  logic                    dec_q, dec_d;
  logic [XTEA_BLOCK_W-1:0] out_data_q, out_data_d;

  logic [31:0] cv0 [UNROLL+1];
  logic [31:0] cv1 [UNROLL+1];
  logic [31:0] csum[UNROLL+1];

  assign cv0[0]  = v0_q;
  assign cv1[0]  = v1_q;
  assign csum[0] = sum_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    xtea_round #(.DELTA(DELTA)) u_round (
      .v0_i     (cv0[g]),
      .v1_i     (cv1[g]),
      .sum_i    (csum[g]),
      .key_i    (key_q),
      .decrypt_i(dec_q),
      .v0_o     (cv0[g+1]),
      .v1_o     (cv1[g+1]),
      .sum_o    (csum[g+1])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    sum_d      = sum_q;
    key_d      = key_q;
    dec_d      = dec_q;
    out_data_d = out_data_q;
    in_ready   = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        v0_d  = cv0[UNROLL];
        v1_d  = cv1[UNROLL];
        sum_d = csum[UNROLL];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS - 1)) begin
          out_data_d = {cv0[UNROLL], cv1[UNROLL]};
          state_d    = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Accept overrides the DONE->IDLE exit so back-to-back blocks skip IDLE.
    if (in_valid && in_ready) begin
      v0_d    = in_data[63:32];
      v1_d    = in_data[31:0];
      key_d   = in_key;
      dec_d   = in_decrypt;
      sum_d   = init_sum(in_decrypt, ROUNDS, DELTA);
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      v0_q       <= '0;
      v1_q       <= '0;
      sum_q      <= '0;
      key_q      <= '0;
      dec_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      sum_q      <= sum_d;
      key_q      <= key_d;
      dec_q      <= dec_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule
